pipeline_stall_ctrl: RTL and testbench
======================================

Name: pipeline_stall_ctrl

Overview:
- Responder side of the hazard-request interface: accepts load-use and branch-use stall requests from the hazard unit and drives the pipeline latch enables and flushes.
- Returns one-cycle done pulses that clear the requester's held request.
- Sits between the hazard unit, the four pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB), the PC and the memory-hit signals.
- Also handles global memory freeze, jump redirect flush and halt.

Parameters:
LU_BUBBLES, 2, bubbles inserted per load-use request (1..7)
BR_TIMEOUT, 4, max non-frozen cycles in BR_WAIT before br_timeout sets
CNT_W, 16, stall-counter width (used only with STALL_COUNT_EN)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, synchronous, active-high
load_use  in  1  load-use stall request, level, held until lu_done
jump_use  in  1  branch-use stall request, level, held until ju_done
ihit  in  1  instruction fetch complete this cycle
dmem_req  in  1  MEM stage has a data access
dhit  in  1  data access complete this cycle
branch_resolved  in  1  EX stage has resolved the branch
branch_taken  in  1  valid with branch_resolved
jump_redirect  in  1  J/JAL/JR redirect this cycle
halt  in  1  halt instruction reached WB
pc_en  out  1  PC register load enable
if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  latch enables
if_id_flush, id_ex_flush  out  1 each  synchronous latch clear (bubble)
pc_redirect  out  1  select branch target for next PC
lu_done  out  1  one-cycle pulse, load-use serviced
ju_done  out  1  one-cycle pulse, branch-use serviced
br_timeout  out  1  sticky error flag
halted  out  1  core halted

Behaviour:
- Synchronous active-high reset:
  - state=RUN; bubble counter=0; pending_ju=0; br_timeout=0; halted=0.
  - During reset, all enables, flushes, pc_redirect and done pulses are 0.
- freeze = (dmem_req & ~dhit) | (~ihit & state==RUN).
  - During freeze: all enables 0, flushes 0, no state, counter or timer change, no done pulse.
- States: RUN, LU_STALL, LU_DONE, BR_WAIT, HALT.
- RUN:
  - Outputs: pc_en = all latch enables = 1; flushes 0.
  - Transitions:
    - halt -> HALT (highest priority).
    - load_use -> LU_STALL, counter=LU_BUBBLES. If jump_use is also 1, set pending_ju.
    - jump_use alone -> BR_WAIT, timer=0.
    - jump_redirect with no request -> if_id_flush=1 for that cycle; stay in RUN.
- LU_STALL:
  - Outputs: pc_en=0, if_id_en=0, id_ex_flush=1; ex_mem_en=mem_wb_en=1.
  - Counter decrements per non-frozen cycle; at counter==1 -> LU_DONE.
  - ID/EX receives exactly LU_BUBBLES bubbles.
- LU_DONE:
  - Outputs: lu_done=1 for one cycle, pipeline runs as in RUN.
  - Next state: BR_WAIT if pending_ju (clear pending_ju), else RUN.
  - load_use ignored in this cycle.
- BR_WAIT:
  - Outputs: pc_en=0; if_id_en=1 with if_id_flush=1 (fetch bubble); other stages enabled.
  - On branch_resolved:
    - ju_done=1 that cycle; next state RUN.
    - If branch_taken: pc_redirect=1, pc_en=1, id_ex_flush=1.
  - Timer increments per non-frozen cycle. Reaching BR_TIMEOUT sets br_timeout (sticky until reset) and forces -> RUN with ju_done=1.
- HALT:
  - All enables 0, halted=1; exit only by reset.
- Other rules:
  - Done pulses never assert in consecutive cycles for the same request.
  - A request still high the cycle after its done pulse is treated as new.
  - halt in LU_STALL/BR_WAIT is honored only after returning to RUN.
  - Reset mid-stall abandons the stall with no done pulse.

Optional Feature:
- Macro STALL_COUNT_EN.
- Defined:
  - Outputs lu_stall_cycles and br_stall_cycles, CNT_W each.
  - Each counts non-frozen cycles in LU_STALL and BR_WAIT respectively.
  - Saturating at all-ones; cleared by reset.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then ihit=1, no requests -> pc_en and all enables 1 each cycle; done pulses 0; halted 0.
- load_use=1 held, LU_BUBBLES=2 -> pc_en=0 and id_ex_flush=1 for exactly 2 cycles, lu_done pulse on 3rd cycle, back to RUN on 4th.
- jump_use=1, branch_resolved=1 with branch_taken=1 two cycles later -> if_id_flush for 2 cycles; then pc_redirect=1, id_ex_flush=1, ju_done=1 in the same cycle.
- load_use and jump_use both raised in the same cycle -> LU sequence first, lu_done, then BR_WAIT entry, ju_done after resolution; exactly one pulse each.
- dmem_req=1, dhit=0 for 3 cycles mid-LU_STALL -> all enables 0, counter frozen; total bubbles still 2.
- jump_use with no branch_resolved -> br_timeout=1 after 4 cycles, ju_done pulse, RUN. With STALL_COUNT_EN defined: br_stall_cycles=4.

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: hazard-request responder driving latch enables/flushes; STALL_COUNT_EN adds stall-cycle counters
module pipeline_stall_ctrl #(
  parameter int LU_BUBBLES = 2,
  parameter int BR_TIMEOUT = 4,
  parameter int CNT_W = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic load_use,
  input  logic jump_use,
  input  logic ihit,
  input  logic dmem_req,
  input  logic dhit,
  input  logic branch_resolved,
  input  logic branch_taken,
  input  logic jump_redirect,
  input  logic halt,
  output logic pc_en,
  output logic if_id_en,
  output logic id_ex_en,
  output logic ex_mem_en,
  output logic mem_wb_en,
  output logic if_id_flush,
  output logic id_ex_flush,
  output logic pc_redirect,
  output logic lu_done,
  output logic ju_done,
  output logic br_timeout,
  output logic halted
`ifdef STALL_COUNT_EN
  ,
  output logic [CNT_W-1:0] lu_stall_cycles,
  output logic [CNT_W-1:0] br_stall_cycles
`endif
);
  localparam int TW = $clog2(BR_TIMEOUT + 1);
  typedef enum logic [2:0] {RUN, LU_STALL, LU_DONE, BR_WAIT, HALT} state_t;
  state_t state, state_n;
  logic [2:0] cnt, cnt_n;
  logic [TW-1:0] tmr, tmr_n;
  logic pend, pend_n, bto_set, freeze, tk;
  assign freeze = (dmem_req & ~dhit) | (~ihit & (state == RUN));
  assign tk = branch_resolved & branch_taken;
  assign halted = ~RST & (state == HALT);
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= RUN;
      cnt <= '0;
      tmr <= '0;
      pend <= 1'b0;
      br_timeout <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      tmr <= tmr_n;
      pend <= pend_n;
      br_timeout <= br_timeout | bto_set;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    tmr_n = tmr;
    pend_n = pend;
    bto_set = 1'b0;
    pc_en = 1'b0;
    if_id_en = 1'b0;
    id_ex_en = 1'b0;
    ex_mem_en = 1'b0;
    mem_wb_en = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    pc_redirect = 1'b0;
    lu_done = 1'b0;
    ju_done = 1'b0;
    if (!RST && !freeze) begin
      case (state)
        RUN: begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '1;
          if_id_flush = jump_redirect & ~load_use & ~jump_use;
          if (halt) state_n = HALT;
          else if (load_use) begin
            state_n = LU_STALL;
            cnt_n = 3'(LU_BUBBLES);
            pend_n = jump_use;
          end else if (jump_use) begin
            state_n = BR_WAIT;
            tmr_n = '0;
          end
        end
        LU_STALL: begin
          {id_ex_en, ex_mem_en, mem_wb_en} = '1;
          id_ex_flush = 1'b1;
          if (cnt == 3'd1) state_n = LU_DONE;
          else cnt_n = cnt - 3'd1;
        end
        LU_DONE: begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '1;
          lu_done = 1'b1;
          state_n = pend ? BR_WAIT : RUN;
          pend_n = 1'b0;
          tmr_n = '0;
        end
        BR_WAIT: begin
          {if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '1;
          if_id_flush = 1'b1;
          pc_en = tk;
          pc_redirect = tk;
          id_ex_flush = tk;
          if (branch_resolved) begin
            ju_done = 1'b1;
            state_n = RUN;
          end else if (tmr == TW'(BR_TIMEOUT - 1)) begin
            ju_done = 1'b1;
            bto_set = 1'b1;
            state_n = RUN;
          end else tmr_n = tmr + 1'b1;
        end
        HALT: state_n = HALT;
        default: state_n = RUN;
      endcase
    end
  end
`ifdef STALL_COUNT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      lu_stall_cycles <= '0;
      br_stall_cycles <= '0;
    end else if (!freeze) begin
      if (state == LU_STALL && !(&lu_stall_cycles)) lu_stall_cycles <= lu_stall_cycles + 1'b1;
      if (state == BR_WAIT && !(&br_stall_cycles)) br_stall_cycles <= br_stall_cycles + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: random and directed stimulus against a behavioural model of the stall controller
module tb_pipeline_stall_ctrl;
  localparam int LU_B = 2;
  localparam int BR_TO = 4;
  localparam int CW = 16;
  localparam int CMAX = (1 << CW) - 1;
  logic CLK = 1'b0;
  logic RST, load_use, jump_use, ihit, dmem_req, dhit, branch_resolved, branch_taken, jump_redirect, halt;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, pc_redirect;
  logic lu_done, ju_done, br_timeout, halted;
`ifdef STALL_COUNT_EN
  logic [CW-1:0] lu_stall_cycles, br_stall_cycles;
`endif
  always #5 CLK = ~CLK;
  pipeline_stall_ctrl #(.LU_BUBBLES(LU_B), .BR_TIMEOUT(BR_TO), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .load_use(load_use), .jump_use(jump_use), .ihit(ihit),
    .dmem_req(dmem_req), .dhit(dhit), .branch_resolved(branch_resolved),
    .branch_taken(branch_taken), .jump_redirect(jump_redirect), .halt(halt),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .pc_redirect(pc_redirect), .lu_done(lu_done), .ju_done(ju_done),
    .br_timeout(br_timeout), .halted(halted)
`ifdef STALL_COUNT_EN
    , .lu_stall_cycles(lu_stall_cycles), .br_stall_cycles(br_stall_cycles)
`endif
  );
  int n_cmp = 0;
  int n_bad = 0;
  int m_bub, m_wait, m_lu_cnt, m_br_cnt, halt_wait;
  bit m_owed, m_br, m_after, m_halt, m_to, m_frz;
  logic [4:0] e_en;
  logic [2:0] e_fl;
  logic [3:0] e_st;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  task automatic model_reset();
    m_bub = 0; m_wait = 0; m_lu_cnt = 0; m_br_cnt = 0;
    m_owed = 0; m_br = 0; m_after = 0; m_halt = 0; m_to = 0; m_frz = 0;
  endtask
  task automatic model_outputs();
    bit idle, tk;
    e_en = '0; e_fl = '0; e_st = '0;
    e_st[1] = m_to;
    if (RST) return;
    e_st[0] = m_halt;
    idle = !m_halt && m_bub == 0 && !m_owed && !m_br;
    m_frz = (dmem_req && !dhit) || (!ihit && idle);
    if (m_halt || m_frz) return;
    if (m_bub > 0) begin
      e_en = 5'b00111; e_fl = 3'b010;
    end else if (m_owed) begin
      e_en = '1; e_st[3] = 1'b1;
    end else if (m_br) begin
      tk = branch_resolved && branch_taken;
      e_en = {tk, 4'b1111};
      e_fl = {1'b1, tk, tk};
      e_st[2] = branch_resolved || (m_wait + 1 == BR_TO);
    end else begin
      e_en = '1;
      e_fl[2] = jump_redirect && !load_use && !jump_use;
    end
  endtask
  task automatic model_step();
    if (RST) begin
      model_reset();
      return;
    end
    if (m_halt || m_frz) return;
    if (m_bub > 0 && m_lu_cnt < CMAX) m_lu_cnt++;
    if (m_br && m_bub == 0 && !m_owed && m_br_cnt < CMAX) m_br_cnt++;
    if (m_bub > 0) begin
      m_bub--;
      if (m_bub == 0) m_owed = 1;
    end else if (m_owed) begin
      m_owed = 0;
      if (m_after) begin
        m_after = 0; m_br = 1; m_wait = 0;
      end
    end else if (m_br) begin
      if (branch_resolved) m_br = 0;
      else begin
        m_wait++;
        if (m_wait == BR_TO) begin
          m_to = 1; m_br = 0;
        end
      end
    end else if (halt) m_halt = 1;
    else if (load_use) begin
      m_bub = LU_B; m_after = jump_use;
    end else if (jump_use) begin
      m_br = 1; m_wait = 0;
    end
  endtask
  task automatic drive(input int c);
    bit lu_d, ju_d, rnd;
    lu_d = e_st[3];
    ju_d = e_st[2];
    rnd = c >= 60;
    halt_wait = m_halt ? halt_wait + 1 : 0;
    RST = c < 3 || halt_wait > 5 || (rnd && $urandom_range(0, 199) == 0);
    ihit = 1; dmem_req = 0; dhit = 1; branch_resolved = 0; branch_taken = 0;
    jump_redirect = 0; halt = 0;
    if (lu_d && !(rnd && $urandom_range(0, 3) == 0)) load_use = 0;
    if (ju_d && !(rnd && $urandom_range(0, 3) == 0)) jump_use = 0;
    if (c == 22) begin
      load_use = 1; jump_use = 1;
    end
    if (c >= 24 && c < 27) begin
      dmem_req = 1; dhit = 0;
    end
    if (c == 30) begin
      branch_resolved = 1; branch_taken = 1;
    end
    if (c == 41) jump_use = 1;
    if (c == 50) jump_redirect = 1;
    if (rnd) begin
      ihit = $urandom_range(0, 7) != 0;
      dmem_req = $urandom_range(0, 2) == 0;
      dhit = $urandom_range(0, 1) == 1;
      branch_resolved = $urandom_range(0, 3) == 0;
      branch_taken = $urandom_range(0, 1) == 1;
      jump_redirect = $urandom_range(0, 4) == 0;
      halt = $urandom_range(0, 79) == 0;
      if (!load_use && $urandom_range(0, 5) == 0) load_use = 1;
      if (!jump_use && $urandom_range(0, 5) == 0) jump_use = 1;
    end
    if (RST) begin
      load_use = 0; jump_use = 0; halt_wait = 0;
    end
  endtask
  initial begin
    RST = 1; load_use = 0; jump_use = 0; ihit = 1; dmem_req = 0; dhit = 1;
    branch_resolved = 0; branch_taken = 0; jump_redirect = 0; halt = 0;
    halt_wait = 0;
    e_en = '0; e_fl = '0; e_st = '0;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      drive(c);
      #1;
      model_outputs();
      check("enables", 32'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}), 32'(e_en));
      check("flushes", 32'({if_id_flush, id_ex_flush, pc_redirect}), 32'(e_fl));
      check("status", 32'({lu_done, ju_done, br_timeout, halted}), 32'(e_st));
`ifdef STALL_COUNT_EN
      check("lu_cnt", 32'(lu_stall_cycles), 32'(m_lu_cnt));
      check("br_cnt", 32'(br_stall_cycles), 32'(m_br_cnt));
`endif
      @(posedge CLK);
      model_step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
